// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// alu_share_arbiter_pkg : ALU control codes and field widths shared by the
//                         arbiter and its users.            Rev 1.0
// ============================================================================
package alu_share_arbiter_pkg;

    localparam int ALU_CTL_W = 4;
    localparam int SHAMT_W   = 5;

    localparam logic [ALU_CTL_W-1:0] C_ALU_AND   = 4'd0;
    localparam logic [ALU_CTL_W-1:0] C_ALU_OR    = 4'd1;
    localparam logic [ALU_CTL_W-1:0] C_ALU_ADD   = 4'd2;
    localparam logic [ALU_CTL_W-1:0] C_ALU_SRLV  = 4'd3;
    localparam logic [ALU_CTL_W-1:0] C_ALU_SRL   = 4'd4;
    localparam logic [ALU_CTL_W-1:0] C_ALU_LUI   = 4'd5;
    localparam logic [ALU_CTL_W-1:0] C_ALU_SUB   = 4'd6;
    localparam logic [ALU_CTL_W-1:0] C_ALU_SLT   = 4'd7;
    localparam logic [ALU_CTL_W-1:0] C_ALU_ORI   = 4'd8;
    localparam logic [ALU_CTL_W-1:0] C_ALU_EQ    = 4'd9;
    localparam logic [ALU_CTL_W-1:0] C_ALU_MUL   = 4'd10;
    localparam logic [ALU_CTL_W-1:0] C_ALU_PASSA = 4'd11;

endpackage : alu_share_arbiter_pkg
`default_nettype wire

// File: rtl/alu_share_arbiter_rr.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, first requester at or above
//              ptr_i, wrapping to the lowest index otherwise.   Rev 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [ID_W-1:0] gnt_idx_o
);

    logic            hi_hit_w;
    logic            any_hit_w;
    logic [ID_W-1:0] hi_idx_w;
    logic [ID_W-1:0] lo_idx_w;

    always_comb begin
        hi_hit_w  = 1'b0;
        any_hit_w = 1'b0;
        hi_idx_w  = '0;
        lo_idx_w  = '0;
        gnt_o     = '0;
        // Scanning downward leaves the lowest qualifying index in each slot.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                any_hit_w = 1'b1;
                lo_idx_w  = ID_W'(i);
                if (i >= int'(ptr_i)) begin
                    hi_hit_w = 1'b1;
                    hi_idx_w = ID_W'(i);
                end
            end
        end
        gnt_idx_o = hi_hit_w ? hi_idx_w : lo_idx_w;
        for (int i = 0; i < NREQ; i++) begin
            if (en_i && any_hit_w && (ID_W'(i) == gnt_idx_o)) begin
                gnt_o[i] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// alu_share_arbiter : shares one external ALU among NREQ requesters through a
//                     2-stage operand/result pipeline.        Rev 1.0
// ============================================================================
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32,
    parameter int ID_W = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NREQ-1:0]           req_valid_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [ALU_CTL_W*NREQ-1:0] req_ctl_i,
    input  logic [W*NREQ-1:0]         req_a_i,
    input  logic [W*NREQ-1:0]         req_b_i,
    input  logic [SHAMT_W*NREQ-1:0]   req_shamt_i,
    output logic [ALU_CTL_W-1:0]      alu_ctl_o,
    output logic [W-1:0]              alu_a_o,
    output logic [W-1:0]              alu_b_o,
    output logic [SHAMT_W-1:0]        alu_shamt_o,
    input  logic [W-1:0]              alu_out_i,
    input  logic                      alu_zero_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [W-1:0]              rsp_data_o,
    output logic                      rsp_zero_o,
    output logic                      busy_o
);

    logic                 v1_q, v1_d;
    logic [ID_W-1:0]      id1_q, id1_d;
    logic [ALU_CTL_W-1:0] ctl1_q, ctl1_d;
    logic [W-1:0]         a1_q, a1_d, b1_q, b1_d;
    logic [SHAMT_W-1:0]   shamt1_q, shamt1_d;
    logic                 v2_q, v2_d;
    logic [ID_W-1:0]      id2_q, id2_d;
    logic [W-1:0]         data2_q, data2_d;
    logic                 zero2_q, zero2_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;

    logic                 s2_free_w, s1_adv_w, s1_free_w;
    logic [NREQ-1:0]      gnt_w;
    logic [ID_W-1:0]      gnt_idx_w;

    assign s2_free_w = !v2_q || rsp_ready_i;
    assign s1_adv_w  = v1_q && s2_free_w;
    assign s1_free_w = !v1_q || s1_adv_w;

    // Reset gates the grant so nothing is accepted while the pipe is held clear.
    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .en_i      (s1_free_w && !rst_i),
        .gnt_o     (gnt_w),
        .gnt_idx_o (gnt_idx_w)
    );

    always_comb begin
        v1_d     = v1_q;
        id1_d    = id1_q;
        ctl1_d   = ctl1_q;
        a1_d     = a1_q;
        b1_d     = b1_q;
        shamt1_d = shamt1_q;
        v2_d     = v2_q;
        id2_d    = id2_q;
        data2_d  = data2_q;
        zero2_d  = zero2_q;
        ptr_d    = ptr_q;

        if (s1_free_w) begin
            v1_d = |gnt_w;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_w[i]) begin
                id1_d    = gnt_idx_w;
                ctl1_d   = req_ctl_i[ALU_CTL_W*i +: ALU_CTL_W];
                a1_d     = req_a_i[W*i +: W];
                b1_d     = req_b_i[W*i +: W];
                shamt1_d = req_shamt_i[SHAMT_W*i +: SHAMT_W];
                ptr_d    = (gnt_idx_w == ID_W'(NREQ - 1)) ? '0 : gnt_idx_w + ID_W'(1);
            end
        end

        if (s2_free_w) begin
            v2_d = v1_q;
            if (v1_q) begin
                id2_d   = id1_q;
                data2_d = alu_out_i;
                zero2_d = alu_zero_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q     <= 1'b0;
            id1_q    <= '0;
            ctl1_q   <= '0;
            a1_q     <= '0;
            b1_q     <= '0;
            shamt1_q <= '0;
            v2_q     <= 1'b0;
            id2_q    <= '0;
            data2_q  <= '0;
            zero2_q  <= 1'b0;
            ptr_q    <= '0;
        end else begin
            v1_q     <= v1_d;
            id1_q    <= id1_d;
            ctl1_q   <= ctl1_d;
            a1_q     <= a1_d;
            b1_q     <= b1_d;
            shamt1_q <= shamt1_d;
            v2_q     <= v2_d;
            id2_q    <= id2_d;
            data2_q  <= data2_d;
            zero2_q  <= zero2_d;
            ptr_q    <= ptr_d;
        end
    end

    assign req_ready_o = gnt_w;
    assign alu_ctl_o   = ctl1_q;
    assign alu_a_o     = a1_q;
    assign alu_b_o     = b1_q;
    assign alu_shamt_o = shamt1_q;
    assign rsp_valid_o = v2_q;
    assign rsp_id_o    = id2_q;
    assign rsp_data_o  = data2_q;
    assign rsp_zero_o  = zero2_q;
    assign busy_o      = v1_q || v2_q;

endmodule : alu_share_arbiter
`default_nettype wire
